// File: rtl/signed_product_accumulator.sv
// ---------------------------------------------------------------------------
// signed_product_accumulator
//
// Purpose:
//   Sits downstream of the signed 8x8 multiplier. It takes a stream of
//   two's-complement products and adds up each run of products into a wider
//   accumulator. A run is a dot-product segment whose final beat carries
//   in_last. Each finished sum is presented together with the element count
//   and a sticky signed-overflow flag, and is held until the consumer takes it.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   product beat valid
//   in_ready   out  beat can be accepted this cycle (!out_valid || out_ready)
//   in_prod    in   PROD_W signed product
//   in_last    in   beat closes the current run
//   out_valid  out  finished result is held
//   out_ready  in   consumer takes the result
//   out_acc    out  ACC_W signed run sum
//   out_cnt    out  CNT_W element count (saturates at all-ones)
//   out_ovf    out  signed overflow happened somewhere in the run
//
// Build option:
//   SIGNED_ACC_SAT_EN - when defined, an overflowing addition clamps to the
//   signed ACC_W max/min instead of wrapping. out_ovf is reported either way.
// ---------------------------------------------------------------------------
module signed_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic               deliver;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   base;
    logic [CNT_W-1:0]   cnt_base;
    logic               ovf_base;
    logic [ACC_W-1:0]   sum_raw;
    logic [ACC_W-1:0]   sum_next;
    logic               ovf_step;
    logic [CNT_W-1:0]   cnt_inc;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    assign out_acc   = out_acc_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

    // Sign-extend the product into the accumulator width.
    assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};

    // An accept while in HOLD only happens together with a deliver, so the
    // beat opens a fresh run: its base is zero, not the stale run state.
    always_comb begin
        base     = acc_q;
        cnt_base = cnt_q;
        ovf_base = ovf_q;
        if (state_q == HOLD) begin
            base     = '0;
            cnt_base = '0;
            ovf_base = 1'b0;
        end
    end

    assign sum_raw  = base + prod_ext;

    // Overflow: operands agree in sign but the sum does not.
    assign ovf_step = (base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_raw[ACC_W-1] != base[ACC_W-1]);

`ifdef SIGNED_ACC_SAT_EN
    // Clamp towards the sign both operands shared.
    always_comb begin
        sum_next = sum_raw;
        if (ovf_step) begin
            sum_next = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    // Plain two's-complement wrap; the min/max constants are unused here.
    always_comb begin
        sum_next = sum_raw;
        if (ovf_step && (ACC_MAX == ACC_MIN)) begin
            sum_next = sum_raw;
        end
    end
`endif

    // Element counter sticks at all-ones on very long runs.
    assign cnt_inc = (&cnt_base) ? cnt_base : cnt_base + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_acc_d = out_acc_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;

        if (accept) begin
            if (in_last) begin
                out_acc_d = sum_next;
                out_cnt_d = cnt_inc;
                out_ovf_d = ovf_base | ovf_step;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
                state_d   = HOLD;
            end else begin
                acc_d     = sum_next;
                cnt_d     = cnt_inc;
                ovf_d     = ovf_base | ovf_step;
                state_d   = ACCUM;
            end
        end else if (deliver) begin
            // Result taken with no new beat: output registers keep stale data.
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_acc_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_acc_q <= out_acc_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_signed_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_signed_product_accumulator
//
// Self-checking bench: a driver issues product beats, a reference model
// (plain integer arithmetic) predicts each run result and pushes it into a
// scoreboard queue, and a monitor pops and compares whenever the DUT hands a
// result over. Directed scenarios are followed by 1000 randomized runs.
// ---------------------------------------------------------------------------
module tb_signed_product_accumulator;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int CNT_W  = 5;
    localparam longint ACC_MAXV = 64'sd8388607;
    localparam longint ACC_MINV = -64'sd8388608;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;

    signed_product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     n_results = 0;
    logic   rand_ready = 1'b0;

    // Reference model state: true run value kept in the signed ACC_W range.
    longint m_val  = 0;
    int     m_cnt  = 0;
    logic   m_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_val = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_beat(input logic [PROD_W-1:0] p, input logic last);
        longint t;
        logic [ACC_W-1:0] w;
        exp_t e;
        t = m_val + longint'($signed(p));
        if (t > ACC_MAXV || t < ACC_MINV) begin
            m_ovf = 1'b1;
`ifdef SIGNED_ACC_SAT_EN
            t = (t > ACC_MAXV) ? ACC_MAXV : ACC_MINV;
`endif
        end
        w = t[ACC_W-1:0];
        m_val = longint'($signed(w));
        m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
        if (last) begin
            e.acc = w;
            e.cnt = CNT_W'(m_cnt);
            e.ovf = m_ovf;
            sb.push_back(e);
            model_clear();
        end
    endtask

    // Present one beat and hold it until the DUT accepts it.
    task automatic send_beat(input logic [PROD_W-1:0] p, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 500) begin
                $display("FAIL accept_timeout: in_ready stuck at 0 expected 1");
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk);
        model_beat(p, last);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        int c = 0;
        while ((sb.size() != 0 || out_valid) && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Randomized back-pressure from the consumer when enabled.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: a handshake completes at the next rising edge whenever both
    // sides are high in the middle of the cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_results++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got acc 0x%0h with no result expected", out_acc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_acc", 32'(out_acc), 32'(e.acc));
                check("out_cnt", 32'(out_cnt), 32'(e.cnt));
                check("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin
        logic [PROD_W-1:0] p;
        logic signed [7:0] a8, b8;
        int len;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        model_clear();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_acc",   32'(out_acc),   32'd0);
        check("rst_out_cnt",   32'(out_cnt),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);

        // Three-beat run: 100 - 250 + 16384 = 16234
        send_beat(16'd100, 1'b0);
        send_beat(-16'sd250, 1'b0);
        send_beat(16'd16384, 1'b1);
        check("run3_acc", 32'(out_acc), 32'd16234);
        check("run3_cnt", 32'(out_cnt), 32'd3);
        drain();

        // Single beat held by a stalled consumer
        out_ready = 1'b0;
        send_beat(-16'sd16256, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_out_acc",   32'(out_acc),   32'h00FFC080);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        drain();

        // Back-to-back single-beat runs
        send_beat(16'd5, 1'b1);
        send_beat(16'd7, 1'b1);
        check("b2b_second_acc", 32'(out_acc), 32'd7);
        drain();

        // Long run overflowing the accumulator
        for (int i = 0; i < 600; i++) send_beat(16'd16384, (i == 599));
`ifdef SIGNED_ACC_SAT_EN
        check("long_acc", 32'(out_acc), 32'h007FFFFF);
`else
        check("long_acc", 32'(out_acc), 32'h00960000);
`endif
        check("long_cnt", 32'(out_cnt), 32'd31);
        check("long_ovf", 32'(out_ovf), 32'd1);
        drain();

        // Reset mid-run discards the partial sum
        send_beat(16'd1000, 1'b0);
        send_beat(16'd2000, 1'b0);
        do_reset();
        send_beat(16'd10, 1'b1);
        check("after_rst_acc", 32'(out_acc), 32'd10);
        check("after_rst_cnt", 32'(out_cnt), 32'd1);
        drain();

        // Reset while holding drops the result
        out_ready = 1'b0;
        send_beat(16'd3, 1'b1);
        void'(sb.pop_back());
        do_reset();
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        check("rst_hold_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        idle(2);

        // Randomized runs with gated valid and ready
        rand_ready = 1'b1;
        for (int r = 0; r < 1000; r++) begin
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(30, 40) : $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                p  = 16'(int'(a8) * int'(b8));
                send_beat(p, (k == len - 1));
            end
        end
        drain();
        rand_ready = 1'b0;
        idle(2);
        check("results_seen", 32'(n_results), 32'd1006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_product_accumulator.md
Name: signed_product_accumulator

Overview:
- Downstream stage of the signed 8x8 Booth/Wallace multiplier.
- Consumes its 16-bit two's-complement product stream over a valid/ready handshake.
- Sums a variable-length run of products (a dot-product segment) into a wider accumulator.
- Presents each finished sum with an element count and overflow flag, for use by the Posit FMAU datapath.

Parameters:
- PROD_W, 16, product width, matching the multiplier output.
- ACC_W, 24, accumulator/result width; must be > PROD_W.
- CNT_W, 5, element-counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  stage can accept a product this cycle.
- in_prod  input  PROD_W  signed product.
- in_last  input  1  beat is the final element of the run.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  signed run sum.
- out_cnt  output  CNT_W  number of elements in the run.
- out_ovf  output  1  signed overflow occurred in the run (sticky per run).

Behaviour:
- States:
  - ACCUM (out_valid=0)
  - HOLD (out_valid=1)
- Reset (rst=1 at an edge):
  - State ACCUM; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_acc=0, out_cnt=0, out_ovf=0.
  - Reset mid-run discards the partial sum.
  - Reset in HOLD drops the pending result without a handshake.
- in_ready = !out_valid || out_ready (combinational; zero-bubble when the consumer is ready).
- Accept: in_valid && in_ready.
- Deliver: out_valid && out_ready.
- Sum: next = base + sext(in_prod) at ACC_W bits.
  - base = acc in ACCUM.
  - base = 0 when the accept coincides with a deliver in HOLD.
- Overflow: detected when both operands share a sign and next's sign differs. The flag ORs into the run's ovf.
- Accept without in_last:
  - acc <= next; cnt <= cnt+1, saturating at all-ones.
  - State stays or becomes ACCUM.
- Accept with in_last:
  - out_acc <= next; out_cnt <= cnt+1 (saturating); out_ovf <= ovf | new overflow.
  - acc, cnt, ovf cleared; state HOLD.
  - Latency: result visible the cycle after the last beat.
- Deliver without accept: state -> ACCUM; out_* registers keep their values (don't-care).
- Deliver with accept: acts as the accept case above, starting from a fresh run. A one-element run (in_last on that beat) re-enters HOLD with the new result.
- In HOLD with out_ready=0:
  - in_ready=0 and all outputs stable.
  - in_prod/in_last ignored.
- in_valid=0: no state change; partial acc held indefinitely.
- Run of zero elements cannot occur; in_last only qualifies an accepted beat.

Optional Feature:
- Macro: SIGNED_ACC_SAT_EN.
- Defined:
  - On overflow, next is clamped to the signed ACC_W max (0x7FFFFF at default) when both operands are positive, or min (0x800000) when both are negative.
  - Subsequent beats accumulate from the clamped value.
  - out_ovf is still reported.
- Undefined: two's-complement wrap-around; out_ovf reports the wrap.

Test Plan:
- Reset, then 3 beats 100, -250, 16384 with in_last on the third, out_ready=1.
  -> out_valid one cycle later; out_acc=16234, out_cnt=3, out_ovf=0.
- Single beat -16256 with in_last while out_ready=0 for 4 cycles.
  -> out_valid held; in_ready=0; out_acc=0xFFC080 stable; then out_ready=1 returns in_ready=1.
- Back-to-back runs [5,in_last] and [7,in_last] on consecutive cycles, out_ready=1.
  -> results 5 then 7 in consecutive cycles, no bubble; second sum not contaminated by the first.
- 600 beats of 16384 with in_last on the last beat.
  -> without the macro: wrapped sum 9830400 mod 2^24 = 0x960000 (negative), out_ovf=1, out_cnt=31.
  -> with SIGNED_ACC_SAT_EN: out_acc=0x7FFFFF, out_ovf=1.
- Assert rst for one cycle after 2 beats (no in_last).
  -> next run of [10,in_last] gives out_acc=10, out_cnt=1.
- Assert rst while in HOLD.
  -> out_valid=0 next cycle; in_ready=1.
- Random in_valid/out_ready gating over 1000 runs with random 8x8 operand products.
  -> each out_acc equals the reference sum mod 2^24; no result is lost or duplicated.
